// File: rtl/mat_mul_param_if.sv
// mat_mul_param_if: operation bus for mat_mul_param.
//   master : drives start/size/signed_mode/operands, observes result/status
//   slave  : the multiplier side
// Signals: start, size, signed_mode, data_inA, data_inB (requests);
//          data_out, busy, finish, err (responses). Operands and results
//          are flat row-major vectors, element e at [e*W +: W].
interface mat_mul_param_if #(
  parameter int MAX_SIZE = 13,
  parameter int DATA_BW  = 16,
  parameter int OUT_BW   = 2*DATA_BW,
  parameter int SIZE_BW  = $clog2(MAX_SIZE+1)
);
  logic                                start;
  logic [SIZE_BW-1:0]                  size;
  logic                                signed_mode;
  logic [MAX_SIZE*MAX_SIZE*DATA_BW-1:0] data_inA;
  logic [MAX_SIZE*MAX_SIZE*DATA_BW-1:0] data_inB;
  logic [MAX_SIZE*MAX_SIZE*OUT_BW-1:0]  data_out;
  logic                                busy;
  logic                                finish;
  logic                                err;

  modport master (
    output start, size, signed_mode, data_inA, data_inB,
    input  data_out, busy, finish, err
  );
  modport slave (
    input  start, size, signed_mode, data_inA, data_inB,
    output data_out, busy, finish, err
  );
endinterface

// File: rtl/mat_mul_param.sv
// mat_mul_param: sequential C = A x B for N x N matrices, 1 <= N <= MAX_SIZE,
// one multiply-accumulate per cycle. N and signed/unsigned mode are chosen
// per operation; operands are latched at start so the host may change them.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : mat_mul_param_if.slave (start/size/signed_mode/data_inA/data_inB
//            in; data_out/busy/finish/err out)
// Build option: define MATMUL_SAT_EN to saturate each result element to the
// OUT_BW range instead of keeping its low OUT_BW bits.
module mat_mul_param #(
  parameter int MAX_SIZE = 13,
  parameter int DATA_BW  = 16,
  parameter int OUT_BW   = 2*DATA_BW,
  parameter int SIZE_BW  = $clog2(MAX_SIZE+1),
  parameter int ACC_BW   = 2*DATA_BW+SIZE_BW
)(
  input  logic             clk,
  input  logic             rst_n,
  mat_mul_param_if.slave   bus
);
  localparam int NEL     = MAX_SIZE*MAX_SIZE;
  localparam int IDX_BW  = $clog2(NEL);
  localparam int PROD_BW = 2*DATA_BW;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_WRITE, S_DONE} state_t;
  state_t r_state, w_state_nxt;

  logic [NEL-1:0][DATA_BW-1:0] r_a, r_b;
  logic [NEL-1:0][OUT_BW-1:0]  r_c;
  logic [SIZE_BW-1:0]          r_n, r_i, r_j, r_k;
  logic                        r_sgn;
  logic [ACC_BW-1:0]           r_acc;
  logic                        r_finish, r_err, r_err_arm;

  logic                        w_size_ok, w_k_last, w_j_last, w_i_last, w_err_fire;
  logic [IDX_BW-1:0]           w_a_idx, w_b_idx, w_c_idx;
  logic [DATA_BW-1:0]          w_a_el, w_b_el;
  logic [PROD_BW-1:0]          w_a_ext, w_b_ext, w_prod;
  logic [ACC_BW-1:0]           w_prod_ext;
  logic [OUT_BW-1:0]           w_fit;

  assign w_size_ok = (bus.size != '0) && (bus.size <= SIZE_BW'(MAX_SIZE));
  assign w_k_last  = (r_k == r_n - SIZE_BW'(1));
  assign w_j_last  = (r_j == r_n - SIZE_BW'(1));
  assign w_i_last  = (r_i == r_n - SIZE_BW'(1));

  // err only fires once per start assertion; r_err_arm re-arms when start drops
  assign w_err_fire = (r_state == S_IDLE) && bus.start && !w_size_ok && r_err_arm;

  assign w_a_idx = IDX_BW'(r_i*MAX_SIZE + r_k);
  assign w_b_idx = IDX_BW'(r_k*MAX_SIZE + r_j);
  assign w_c_idx = IDX_BW'(r_i*MAX_SIZE + r_j);
  assign w_a_el  = r_a[w_a_idx];
  assign w_b_el  = r_b[w_b_idx];

  // Extending both operands to 2*DATA_BW makes the low 2*DATA_BW product bits
  // correct for either signedness, so one multiplier serves both modes.
  assign w_a_ext    = r_sgn ? {{DATA_BW{w_a_el[DATA_BW-1]}}, w_a_el} : {{DATA_BW{1'b0}}, w_a_el};
  assign w_b_ext    = r_sgn ? {{DATA_BW{w_b_el[DATA_BW-1]}}, w_b_el} : {{DATA_BW{1'b0}}, w_b_el};
  assign w_prod     = w_a_ext * w_b_ext;
  assign w_prod_ext = r_sgn ? {{(ACC_BW-PROD_BW){w_prod[PROD_BW-1]}}, w_prod}
                            : {{(ACC_BW-PROD_BW){1'b0}}, w_prod};

`ifdef MATMUL_SAT_EN
  // Out of range when the bits above the result window are not a pure
  // sign extension (signed) or not all zero (unsigned).
  logic [ACC_BW-OUT_BW:0]   w_hi_s;
  logic [ACC_BW-OUT_BW-1:0] w_hi_u;
  always_comb begin
    w_hi_s = r_acc[ACC_BW-1:OUT_BW-1];
    w_hi_u = r_acc[ACC_BW-1:OUT_BW];
    w_fit  = r_acc[OUT_BW-1:0];
    if (r_sgn) begin
      if (!(&w_hi_s) && (|w_hi_s))
        w_fit = r_acc[ACC_BW-1] ? {1'b1, {(OUT_BW-1){1'b0}}} : {1'b0, {(OUT_BW-1){1'b1}}};
    end else if (|w_hi_u) begin
      w_fit = '1;
    end
  end
`else
  logic w_unused_hi;
  assign w_unused_hi = ^r_acc[ACC_BW-1:OUT_BW];
  assign w_fit       = r_acc[OUT_BW-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start && w_size_ok) w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = S_MAC;
      S_MAC:   if (w_k_last) w_state_nxt = S_WRITE;
      S_WRITE: w_state_nxt = (w_i_last && w_j_last) ? S_DONE : S_MAC;
      // leave DONE only after finish has been presented and start released
      S_DONE:  if (r_finish && !bus.start) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_c       <= '0;
      r_n       <= '0;
      r_i       <= '0;
      r_j       <= '0;
      r_k       <= '0;
      r_sgn     <= 1'b0;
      r_acc     <= '0;
      r_finish  <= 1'b0;
      r_err     <= 1'b0;
      r_err_arm <= 1'b1;
    end else begin
      r_err <= w_err_fire;
      if (!bus.start)     r_err_arm <= 1'b1;
      else if (w_err_fire) r_err_arm <= 1'b0;

      // finish is registered one cycle after entering DONE and drops on the
      // edge that sees start low
      r_finish <= (r_state == S_DONE) && !(r_finish && !bus.start);

      case (r_state)
        S_IDLE: if (bus.start && w_size_ok) begin
          r_n   <= bus.size;
          r_sgn <= bus.signed_mode;
          r_a   <= bus.data_inA;
          r_b   <= bus.data_inB;
        end
        S_LOAD: begin
          r_c   <= '0;
          r_i   <= '0;
          r_j   <= '0;
          r_k   <= '0;
          r_acc <= '0;
        end
        S_MAC: begin
          r_acc <= r_acc + w_prod_ext;
          r_k   <= r_k + SIZE_BW'(1);
        end
        S_WRITE: begin
          r_c[w_c_idx] <= w_fit;
          r_acc        <= '0;
          r_k          <= '0;
          if (w_j_last) begin
            r_j <= '0;
            r_i <= r_i + SIZE_BW'(1);
          end else begin
            r_j <= r_j + SIZE_BW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.data_out = r_c;
  assign bus.busy     = (r_state == S_LOAD) || (r_state == S_MAC) || (r_state == S_WRITE);
  assign bus.finish   = r_finish;
  assign bus.err      = r_err;
endmodule

// File: tb/tb_mat_mul_param.sv
// Bench for mat_mul_param: directed 2x2/1x1 vector table, the N=13 reference
// cases, err handshake, operand isolation, finish hold, mid-run reset, and
// random operations checked against a plain-arithmetic matrix model.
module tb_mat_mul_param;
  localparam int MS = 13, DW = 16, OW = 32, NE = MS*MS;
`ifdef MATMUL_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mat_mul_param_if #(.MAX_SIZE(MS), .DATA_BW(DW)) bus();
  mat_mul_param #(.MAX_SIZE(MS), .DATA_BW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0, n_bad = 0;
  logic [15:0] a_m [NE];
  logic [15:0] b_m [NE];
  logic [31:0] exp_c [NE];

  typedef struct {
    int               n;
    bit               s;
    logic [3:0][15:0] a;
    logic [3:0][15:0] b;
    logic [3:0][31:0] c;   // C[0][0], C[0][1], C[1][0], C[1][1]
  } vec_t;
  vec_t tbl [5];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic longint ext(input logic [15:0] v, input bit s);
    shortint sv;
    sv = v;
    return s ? longint'(sv) : longint'({48'd0, v});
  endfunction

  function automatic logic [31:0] fit(input longint acc, input bit s);
    longint lo, hi, r;
    lo = s ? -64'sd2147483648 : 64'sd0;
    hi = s ? 64'sd2147483647 : 64'sd4294967295;
    r  = acc;
    if (SAT_EN) begin
      if (r > hi) r = hi;
      if (r < lo) r = lo;
    end
    return r[31:0];
  endfunction

  task automatic model(input int n, input bit s);
    longint acc;
    for (int e = 0; e < NE; e++) exp_c[e] = '0;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        acc = 0;
        for (int k = 0; k < n; k++) acc += ext(a_m[i*MS+k], s) * ext(b_m[k*MS+j], s);
        exp_c[i*MS+j] = fit(acc, s);
      end
  endtask

  function automatic logic [31:0] dout(input int e);
    return bus.data_out[e*OW +: OW];
  endfunction

  task automatic check_all(input string tag);
    for (int e = 0; e < NE; e++)
      check($sformatf("%s C[%0d][%0d]", tag, e/MS, e%MS), 64'(dout(e)), 64'(exp_c[e]));
  endtask

  task automatic drive_ops(input int n, input bit s);
    for (int e = 0; e < NE; e++) begin
      bus.data_inA[e*DW +: DW] = a_m[e];
      bus.data_inB[e*DW +: DW] = b_m[e];
    end
    bus.size = 4'(n);
    bus.signed_mode = s;
  endtask

  task automatic rand_ops();
    for (int e = 0; e < NE; e++) begin
      a_m[e] = 16'($urandom);
      b_m[e] = 16'($urandom);
    end
  endtask

  // One full operation: start, wait (bounded) for finish, check latency and
  // busy, optionally scramble inputs after the sampling edge, hold start
  // `hold` cycles past finish, then release and check finish falls.
  task automatic run_op(input int n, input bit s, input bit mutate, input int hold);
    int cyc;
    bit done;
    drive_ops(n, s);
    @(negedge clk);
    bus.start = 1'b1;
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < 3000) begin
      @(posedge clk);
      cyc++;
      #1;
      if (bus.finish) done = 1'b1;
      if (mutate && cyc == 1) begin
        for (int e = 0; e < NE; e++) bus.data_inA[e*DW +: DW] = 16'($urandom);
        bus.size = 4'd2;
        bus.signed_mode = ~s;
      end
    end
    check($sformatf("latency N=%0d", n), 64'(cyc-1), 64'(n*n*(n+1)+2));
    if (!done) begin
      bus.start = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      return;
    end
    check("busy in DONE", 64'(bus.busy), 64'd0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check($sformatf("finish hold %0d", h), 64'(bus.finish), 64'd1);
    end
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("finish drops", 64'(bus.finish), 64'd0);
    check("busy after release", 64'(bus.busy), 64'd0);
  endtask

  function automatic vec_t mk(input int n, input bit s,
      input logic [15:0] a0, a1, a2, a3, input logic [15:0] b0, b1, b2, b3,
      input logic [31:0] c0, c1, c2, c3);
    vec_t v;
    v.n = n; v.s = s;
    v.a[0] = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = a3;
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
    v.c[0] = c0; v.c[1] = c1; v.c[2] = c2; v.c[3] = c3;
    return v;
  endfunction

  initial begin
    int pos, n;
    bit s;
    logic [31:0] ffff_exp;

    tbl[0] = mk(2, 1, 16'd1, 16'hFFFE, 16'd3, 16'd4,  16'd5, 16'd6, 16'hFFF9, 16'd8,
                32'd19, 32'hFFFFFFF6, 32'hFFFFFFF3, 32'd50);
    tbl[1] = mk(2, 0, 16'd1, 16'hFFFE, 16'd3, 16'd4,  16'd5, 16'd6, 16'hFFF9, 16'd8,
                32'hFFF70013, 32'h0007FFF6, 32'h0003FFF3, 32'd50);
    tbl[2] = mk(1, 1, 16'hFFFD, 16'd7, 16'd7, 16'd7,  16'hFFFB, 16'd9, 16'd9, 16'd9,
                32'd15, 32'd0, 32'd0, 32'd0);
    tbl[3] = mk(1, 0, 16'h8000, 16'd7, 16'd7, 16'd7,  16'd2, 16'd9, 16'd9, 16'd9,
                32'h00010000, 32'd0, 32'd0, 32'd0);
    tbl[4] = mk(2, 1, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000,
                16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000,
                32'h7FFE0002, 32'h80010000, 32'h80010000,
                SAT_EN ? 32'h7FFFFFFF : 32'h80000000);

    bus.start = 1'b0; bus.size = '0; bus.signed_mode = 1'b0;
    bus.data_inA = '0; bus.data_inB = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset busy",   64'(bus.busy),   64'd0);
    check("reset finish", 64'(bus.finish), 64'd0);
    check("reset err",    64'(bus.err),    64'd0);
    check("reset dout",   64'(|bus.data_out), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // directed small-matrix table; junk elsewhere must not leak in
    for (int t = 0; t < 5; t++) begin
      rand_ops();
      for (int q = 0; q < 4; q++) begin
        pos = (q/2)*MS + q%2;
        a_m[pos] = tbl[t].a[q];
        b_m[pos] = tbl[t].b[q];
      end
      run_op(tbl[t].n, tbl[t].s, 1'b0, 0);
      for (int q = 0; q < 4; q++)
        check($sformatf("tbl%0d C[%0d][%0d]", t, q/2, q%2),
              64'(dout((q/2)*MS + q%2)), 64'(tbl[t].c[q]));
      check($sformatf("tbl%0d C[2][2]", t), 64'(dout(2*MS+2)), 64'd0);
      check($sformatf("tbl%0d C[12][12]", t), 64'(dout(NE-1)), 64'd0);
    end

    // N=13 ramp
    for (int h = 0; h < NE; h++) begin
      a_m[h] = 16'(h);
      b_m[h] = 16'(NE + h);
    end
    run_op(13, 1'b0, 1'b0, 0);
    check("ramp C[0][0]", 64'(dout(0)), 64'd21632);
    model(13, 1'b0);
    check_all("ramp");

    // N=13 all ones, largest unsigned accumulation
    for (int h = 0; h < NE; h++) begin
      a_m[h] = 16'hFFFF;
      b_m[h] = 16'hFFFF;
    end
    ffff_exp = SAT_EN ? 32'hFFFFFFFF : 32'hFFE6000D;
    run_op(13, 1'b0, 1'b0, 0);
    check("ffff C[0][0]",   64'(dout(0)),    64'(ffff_exp));
    check("ffff C[12][12]", 64'(dout(NE-1)), 64'(ffff_exp));
    model(13, 1'b0);
    check_all("ffff");

    // illegal sizes: one-cycle err each, no activity, result kept
    @(negedge clk);
    bus.size = 4'd0; bus.start = 1'b1;
    @(posedge clk); #1;
    check("err size0 pulse", 64'(bus.err), 64'd1);
    check("err size0 busy",  64'(bus.busy), 64'd0);
    @(posedge clk); #1;
    check("err size0 one-cycle", 64'(bus.err), 64'd0);
    @(posedge clk); #1;
    check("err no re-pulse", 64'(bus.err), 64'd0);
    check("err finish", 64'(bus.finish), 64'd0);
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk); bus.size = 4'd14; bus.start = 1'b1;
    @(posedge clk); #1;
    check("err size14 pulse", 64'(bus.err), 64'd1);
    @(posedge clk); #1;
    check("err size14 one-cycle", 64'(bus.err), 64'd0);
    check("err size14 busy", 64'(bus.busy), 64'd0);
    @(negedge clk); bus.start = 1'b0;
    check_all("err keep");

    // operand isolation and finish hold
    rand_ops();
    model(4, 1'b1);
    run_op(4, 1'b1, 1'b1, 10);
    check_all("latched");

    // random operations
    for (int r = 0; r < 5; r++) begin
      n = $urandom_range(1, 7);
      s = 1'($urandom_range(0, 1));
      rand_ops();
      model(n, s);
      run_op(n, s, 1'b0, 0);
      check_all($sformatf("rand%0d", r));
    end

    // reset in the middle of an N=13 run
    rand_ops();
    drive_ops(13, 1'b0);
    @(negedge clk); bus.start = 1'b1;
    repeat (100) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("midrst busy",   64'(bus.busy),   64'd0);
    check("midrst finish", 64'(bus.finish), 64'd0);
    check("midrst dout",   64'(|bus.data_out), 64'd0);
    bus.start = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    rand_ops();
    model(2, 1'b1);
    run_op(2, 1'b1, 1'b0, 0);
    check_all("postrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
